mul4_tournament_ctrl: RTL and testbench

// Sequencer and scoring engine for evaluating a population of evolved 2x2-bit vector multiplier

---
 rtl/mul4_tournament_if.sv | 32 +++
 rtl/mul4_tournament_ctrl.sv | 141 ++++++++++++++
 tb/tb_mul4_tournament_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul4_tournament_if.sv
// Harness bus between the tournament controller and the bench/candidate array.
// slave = controller side, master = harness/driver side.
interface mul4_tournament_if #(
  parameter int NCAND = 8
);
  localparam int SW = $clog2(NCAND);

  logic          start;
  logic          abort;
  logic [SW-1:0] cand_sel;
  logic [15:0]   a1, a0, b1, b0;
  logic [15:0]   y3, y2, y1, y0;
  logic          busy;
  logic          score_valid;
  logic [6:0]    score;
  logic [SW-1:0] score_idx;
  logic          done;
  logic [SW-1:0] best_idx;
  logic [6:0]    best_score;

  modport slave (
    input  start, abort, y3, y2, y1, y0,
    output cand_sel, a1, a0, b1, b0, busy, score_valid, score, score_idx,
           done, best_idx, best_score
  );

  modport master (
    output start, abort, y3, y2, y1, y0,
    input  cand_sel, a1, a0, b1, b0, busy, score_valid, score, score_idx,
           done, best_idx, best_score
  );
endinterface

// File: rtl/mul4_tournament_ctrl.sv
// Tournament sequencer/scorer for 2x2-bit vector multiplier candidates.
// Optional MUL4_EARLY_EXIT_EN: a perfect score (64) ends the run at once.
module mul4_tournament_ctrl #(
  parameter int NCAND  = 8,
  parameter int SETTLE = 1
) (
  input logic               clk,
  input logic               rst,
  mul4_tournament_if.slave  bus
);
  localparam int SW = $clog2(NCAND);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] LAST = SW'(NCAND - 1);
  localparam logic [63:0]   EXP  = {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0};

  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, SCORE, FIN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    score_q, score_d;
  logic [SW-1:0] idx_q, idx_d;
  logic          sv_q, sv_d;
  logic [SW-1:0] best_idx_q, best_idx_d;
  logic [6:0]    best_score_q, best_score_d;
  logic [63:0]   y_q;
  logic [6:0]    cur;
  logic          busy;
  logic          last;

  function automatic logic [6:0] match_count(input logic [63:0] y);
    logic [63:0] m;
    logic [6:0]  n;
    m = ~(y ^ EXP);
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {6'd0, m[i]};
    return n;
  endfunction

  assign cur  = match_count(y_q);
  assign busy = (state_q == DRIVE) || (state_q == SAMPLE) || (state_q == SCORE);

`ifdef MUL4_EARLY_EXIT_EN
  assign last = (sel_q == LAST) || (cur == 7'd64);
`else
  assign last = (sel_q == LAST);
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    score_d      = score_q;
    idx_d        = idx_q;
    sv_d         = 1'b0;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    // Abort beats everything, including start in the same IDLE cycle.
    if (bus.abort && (busy || state_q == IDLE)) begin
      state_d = IDLE;
      sel_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_d      = DRIVE;
          sel_d        = '0;
          cnt_d        = '0;
          best_idx_d   = '0;
          best_score_d = '0;
        end
        DRIVE: begin
          if (cnt_q == CW'(SETTLE - 1)) state_d = SAMPLE;
          else cnt_d = cnt_q + 1'b1;
        end
        SAMPLE: state_d = SCORE;
        SCORE: begin
          score_d = cur;
          idx_d   = sel_q;
          sv_d    = 1'b1;
          // Strict compare keeps the lower index on ties.
          if (sel_q == '0 || cur > best_score_q) begin
            best_idx_d   = sel_q;
            best_score_d = cur;
          end
          if (last) begin
            state_d = FIN;
          end else begin
            state_d = DRIVE;
            sel_d   = sel_q + 1'b1;
            cnt_d   = '0;
          end
        end
        FIN: begin
          state_d = IDLE;
          sel_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      score_q      <= '0;
      idx_q        <= '0;
      sv_q         <= 1'b0;
      best_idx_q   <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      score_q      <= score_d;
      idx_q        <= idx_d;
      sv_q         <= sv_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
    end
  end

  // Candidate outputs are only consumed in SCORE, so the capture needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == SAMPLE) y_q <= {bus.y3, bus.y2, bus.y1, bus.y0};
  end

  assign bus.cand_sel    = sel_q;
  assign bus.a1          = busy ? 16'hFF00 : 16'h0000;
  assign bus.a0          = busy ? 16'hF0F0 : 16'h0000;
  assign bus.b1          = busy ? 16'hCCCC : 16'h0000;
  assign bus.b0          = busy ? 16'hAAAA : 16'h0000;
  assign bus.busy        = busy;
  assign bus.score_valid = sv_q;
  assign bus.score       = score_q;
  assign bus.score_idx   = idx_q;
  assign bus.done        = (state_q == FIN);
  assign bus.best_idx    = best_idx_q;
  assign bus.best_score  = best_score_q;
endmodule

// File: tb/tb_mul4_tournament_ctrl.sv
// Directed bench for mul4_tournament_ctrl with a score scoreboard.
module tb_mul4_tournament_ctrl;
  localparam int NC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul4_tournament_if #(.NCAND(NC)) bus ();
  mul4_tournament_if #(.NCAND(NC)) bus2 ();

  mul4_tournament_ctrl #(.NCAND(NC), .SETTLE(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mul4_tournament_ctrl #(.NCAND(NC), .SETTLE(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  localparam logic [63:0] PERFECT = {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0};
  localparam logic [63:0] ONES    = {64{1'b1}};
  localparam logic [63:0] TIE     = {16'hCCCC, 16'hF0F0, 16'h0001, 16'h0000};

  logic [63:0] tbl [NC];
  always_comb {bus.y3, bus.y2, bus.y1, bus.y0} = tbl[bus.cand_sel];
  assign bus2.y3 = '0;
  assign bus2.y2 = '0;
  assign bus2.y1 = '0;
  assign bus2.y0 = '0;
  assign bus2.abort = 1'b0;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int exp_idx_q[$];
  int exp_sc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sc(input logic [63:0] y);
    return $countones(~(y ^ PERFECT));
  endfunction

  task automatic push_run();
    for (int c = 0; c < NC; c++) begin
      exp_idx_q.push_back(c);
      exp_sc_q.push_back(sc(tbl[c]));
`ifdef MUL4_EARLY_EXIT_EN
      if (sc(tbl[c]) == 64) break;
`endif
    end
  endtask

  task automatic fill(input logic [63:0] other, input int k1, input int k2, input logic [63:0] kv);
    for (int c = 0; c < NC; c++) tbl[c] = (c == k1 || c == k2) ? kv : other;
  endtask

  // Scoreboard: every score_valid strobe must match the next expected entry.
  always @(negedge clk) begin
    int ei, es;
    if (bus.score_valid) begin
      if (exp_idx_q.size() == 0) chk("sv_unexpected", 1, 0);
      else begin
        ei = exp_idx_q.pop_front();
        es = exp_sc_q.pop_front();
        chk("score_idx", bus.score_idx, ei);
        chk("score", bus.score, es);
      end
    end
  end

  task automatic run(input string tag, input int bidx, input int bsc, input int cycles, input bit spam);
    int n;
    bit seen;
    push_run();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk({tag, "_busy_first"}, bus.busy, 1);
    chk({tag, "_a1"}, bus.a1, 16'hFF00);
    chk({tag, "_a0"}, bus.a0, 16'hF0F0);
    chk({tag, "_b1"}, bus.b1, 16'hCCCC);
    chk({tag, "_b0"}, bus.b0, 16'hAAAA);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
      else if (spam) bus.start = ~bus.start;
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_cycles"}, n + 1, cycles);
    chk({tag, "_best_idx"}, bus.best_idx, bidx);
    chk({tag, "_best_score"}, bus.best_score, bsc);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    @(posedge clk); #2;
    chk({tag, "_done_strobe"}, bus.done, 0);
    chk({tag, "_queue_empty"}, exp_idx_q.size(), 0);
    chk({tag, "_a1_idle"}, bus.a1, 0);
    exp_idx_q.delete();
    exp_sc_q.delete();
  endtask

  initial begin
    int n, dcnt;
    bit seen;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus2.start = 1'b0;
    fill('0, -1, -1, '0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sv", bus.score_valid, 0);
    chk("rst_a1", bus.a1, 0);
    chk("rst_b0", bus.b0, 0);
    chk("rst_sel", bus.cand_sel, 0);
    chk("rst_best", bus.best_score, 0);
    @(negedge clk) rst = 1'b0;

    // All candidates output zero
    run("zeros", 0, 50, 26, 1'b0);

    // Candidate 5 perfect, others all-ones
    fill(ONES, 5, -1, PERFECT);
`ifdef MUL4_EARLY_EXIT_EN
    run("perfect5", 5, 64, 20, 1'b0);
`else
    run("perfect5", 5, 64, 26, 1'b0);
`endif

    // Tie between candidates 2 and 6
    fill(ONES, 2, 6, TIE);
    run("tie", 2, 37, 26, 1'b0);

    // Abort during SAMPLE of candidate 3
    for (int c = 0; c < 3; c++) begin
      exp_idx_q.push_back(c);
      exp_sc_q.push_back(sc(tbl[c]));
    end
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_sel_before", bus.cand_sel, 3);
    bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_sel", bus.cand_sel, 0);
    chk("abort_best_idx", bus.best_idx, 2);
    chk("abort_best_score", bus.best_score, 37);
    dcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_queue_empty", exp_idx_q.size(), 0);
    exp_idx_q.delete();
    exp_sc_q.delete();
    run("after_abort", 2, 37, 26, 1'b0);

    // start and abort together in IDLE
    @(posedge clk); #1 begin bus.start = 1'b1; bus.abort = 1'b1; end
    @(posedge clk); #1 begin bus.start = 1'b0; bus.abort = 1'b0; end
    chk("start_abort_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1 chk("start_abort_busy_later", bus.busy, 0);

    // Async reset in the middle of a run
    fill('0, -1, -1, '0);
    push_run();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_sel", bus.cand_sel, 0);
    chk("mid_rst_a0", bus.a0, 0);
    chk("mid_rst_score", bus.score, 0);
    chk("mid_rst_sv", bus.score_valid, 0);
    chk("mid_rst_best", bus.best_score, 0);
    exp_idx_q.delete();
    exp_sc_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    dcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    chk("post_rst_quiet", dcnt, 0);
    run("after_rst", 0, 50, 26, 1'b0);

    // start toggled throughout a run
    run("start_spam", 0, 50, 26, 1'b1);

    // SETTLE=3 instance
    @(posedge clk); #1 bus2.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus2.done) seen = 1'b1;
    end
    chk("settle3_done_seen", seen, 1);
    chk("settle3_cycles", n + 1, 42);
    chk("settle3_best_score", bus2.best_score, 50);
    chk("settle3_best_idx", bus2.best_idx, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
